// File: rtl/traffic_ctrl.sv
// Two-road traffic light controller with per-second countdown and emergency overrides.
// Optional feature: define YELLOW_BLINK_EN to blink the yellow lamp (1 s on / 1 s off).
module traffic_ctrl #(
    parameter int unsigned T_MAJ_G = 40,
    parameter int unsigned T_MIN_G = 20,
    parameter int unsigned T_YEL   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       emg_minor,
    input  logic       emg_major,
    input  logic       restart,
    output logic [2:0] major_ryg,
    output logic [2:0] minor_ryg,
    output logic [5:0] count,
    output logic       emg_active
);

    localparam logic [5:0] MajGDur = 6'(T_MAJ_G);
    localparam logic [5:0] MinGDur = 6'(T_MIN_G);
    localparam logic [5:0] YelDur  = 6'(T_YEL);

    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampG = 3'b001;

    typedef enum logic [1:0] {StMajG, StMajY, StMinG, StMinY} state_t;

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic [2:0] major_q, major_d;
    logic [2:0] minor_q, minor_d;
    logic       emg_q, emg_d;
    logic       emg_any;
    logic       yellow_on;

    assign emg_any = emg_major | emg_minor;

    // Next state and count; restart beats emergency freeze, which beats tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (restart) begin
            state_d = StMajG;
            count_d = MajGDur;
        end else if (!emg_any && tick_1hz) begin
            if (count_q > 6'd1) begin
                count_d = count_q - 6'd1;
            end else begin
                unique case (state_q)
                    StMajG: begin state_d = StMajY; count_d = YelDur;  end
                    StMajY: begin state_d = StMinG; count_d = MinGDur; end
                    StMinG: begin state_d = StMinY; count_d = YelDur;  end
                    StMinY: begin state_d = StMajG; count_d = MajGDur; end
                    default: begin state_d = StMajG; count_d = MajGDur; end
                endcase
            end
        end
    end

`ifdef YELLOW_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (restart) begin
            blink_d = 1'b0;
        end else if ((state_d == StMajY || state_d == StMinY) && state_d != state_q) begin
            blink_d = 1'b0;
        end else if (!emg_any && tick_1hz && (state_q == StMajY || state_q == StMinY)) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign yellow_on = ~blink_d;
`else
    assign yellow_on = 1'b1;
`endif

    // Lamps are decoded from the next state so they update on the causing edge.
    always_comb begin
        major_d = LampG;
        minor_d = LampR;
        emg_d   = 1'b0;
        if (emg_major) begin
            major_d = LampG;
            minor_d = LampR;
            emg_d   = 1'b1;
        end else if (emg_minor) begin
            major_d = LampR;
            minor_d = LampG;
            emg_d   = 1'b1;
        end else begin
            unique case (state_d)
                StMajG: begin major_d = LampG;                   minor_d = LampR; end
                StMajY: begin major_d = {1'b0, yellow_on, 1'b0}; minor_d = LampR; end
                StMinG: begin major_d = LampR;                   minor_d = LampG; end
                StMinY: begin major_d = LampR; minor_d = {1'b0, yellow_on, 1'b0}; end
                default: begin major_d = LampG;                  minor_d = LampR; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StMajG;
            count_q <= MajGDur;
            major_q <= LampG;
            minor_q <= LampR;
            emg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            major_q <= major_d;
            minor_q <= minor_d;
            emg_q   <= emg_d;
        end
    end

    assign major_ryg  = major_q;
    assign minor_ryg  = minor_q;
    assign count      = count_q;
    assign emg_active = emg_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: a reference model queues expected outputs per driven cycle,
// which are popped and compared one cycle later.
module tb_traffic_ctrl;

    localparam int unsigned TMaj = 40;
    localparam int unsigned TMin = 20;
    localparam int unsigned TYel = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       emg_minor = 1'b0;
    logic       emg_major = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] major_ryg;
    logic [2:0] minor_ryg;
    logic [5:0] count;
    logic       emg_active;

    traffic_ctrl #(
        .T_MAJ_G(TMaj),
        .T_MIN_G(TMin),
        .T_YEL  (TYel)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .emg_minor (emg_minor),
        .emg_major (emg_major),
        .restart   (restart),
        .major_ryg (major_ryg),
        .minor_ryg (minor_ryg),
        .count     (count),
        .emg_active(emg_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] major;
        logic [2:0] minor;
        logic [5:0] cnt;
        logic       emg;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail = 0;

    // Reference model: 0 MAJ_G, 1 MAJ_Y, 2 MIN_G, 3 MIN_Y
    int m_state = 0;
    int m_count = TMaj;
    bit m_blink = 1'b0;

    function automatic int dur(input int s);
        if (s == 0) return TMaj;
        if (s == 2) return TMin;
        return TYel;
    endfunction

    function automatic exp_t model_out(input bit emn, input bit emj);
        exp_t e;
        bit   yl;
`ifdef YELLOW_BLINK_EN
        yl = ~m_blink;
`else
        yl = 1'b1;
`endif
        e.cnt = 6'(m_count);
        e.emg = emn | emj;
        if (emj) begin
            e.major = 3'b001; e.minor = 3'b100;
        end else if (emn) begin
            e.major = 3'b100; e.minor = 3'b001;
        end else begin
            case (m_state)
                0:       begin e.major = 3'b001;           e.minor = 3'b100; end
                1:       begin e.major = {1'b0, yl, 1'b0}; e.minor = 3'b100; end
                2:       begin e.major = 3'b100;           e.minor = 3'b001; end
                default: begin e.major = 3'b100; e.minor = {1'b0, yl, 1'b0}; end
            endcase
        end
        return e;
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        n_tests++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL queue_empty got %0d entries want >0", exp_q.size());
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (major_ryg === e.major) else begin
            n_fail++;
            $error("FAIL %s major_ryg got %b want %b", t, major_ryg, e.major);
        end
        n_tests++;
        assert (minor_ryg === e.minor) else begin
            n_fail++;
            $error("FAIL %s minor_ryg got %b want %b", t, minor_ryg, e.minor);
        end
        n_tests++;
        assert (count === e.cnt) else begin
            n_fail++;
            $error("FAIL %s count got %0d want %0d", t, count, e.cnt);
        end
        n_tests++;
        assert (emg_active === e.emg) else begin
            n_fail++;
            $error("FAIL %s emg_active got %b want %b", t, emg_active, e.emg);
        end
    endtask

    task automatic step(input bit tk, input bit emn, input bit emj, input bit rs, input bit rn,
                        input string tag);
        @(negedge clk);
        tick_1hz  = tk;
        emg_minor = emn;
        emg_major = emj;
        restart   = rs;
        rst_n     = rn;
        if (!rn) begin
            m_state = 0;
            m_count = TMaj;
            m_blink = 1'b0;
            exp_q.push_back(model_out(1'b0, 1'b0));
        end else begin
            if (rs) begin
                m_state = 0;
                m_count = TMaj;
                m_blink = 1'b0;
            end else if (!(emn || emj) && tk) begin
                if (m_count > 1) begin
                    m_count--;
                    m_blink = ~m_blink;
                end else begin
                    m_state = (m_state + 1) % 4;
                    m_count = dur(m_state);
                    m_blink = 1'b0;
                end
            end
            exp_q.push_back(model_out(emn, emj));
        end
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    bit blink_exp[5];

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_after_reset");

        ticks(40, "maj_g_countdown");
        ticks(5 + 20 + 5, "full_cycle");

        ticks(40 + 5 + 8, "to_min_g_12");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "emg_major_hold");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "emg_release");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "resume_tick");

        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "emg_both");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "emg_both_tick");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "emg_minor_only");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "emg_clear");

        ticks(11 + 5 + 40 + 2, "to_maj_y_3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "restart_with_tick");

        ticks(7, "pre_reset_ticks");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "emg_before_reset");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "reset_mid_phase");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_mid_reset");

        ticks(3, "pre_emg_restart");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "emg_minor_on");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "restart_in_emg");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "emg_off_after_restart");

        ticks(39, "to_maj_g_1");
`ifdef YELLOW_BLINK_EN
        blink_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        blink_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "maj_y_blink");
            n_tests++;
            assert (major_ryg[1] === blink_exp[i]) else begin
                n_fail++;
                $error("FAIL yellow_lamp_s%0d got %b want %b", i, major_ryg[1], blink_exp[i]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "leave_maj_y");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
